// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default sizing for the multi-channel PWM block.
//   pwm_mode_e        edge- or center-aligned counting
//   PWM_WIDTH_DEF     default counter/duty resolution in bits
//   PWM_CHANNELS_DEF  default number of PWM outputs
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int PWM_WIDTH_DEF    = 10;
  localparam int PWM_CHANNELS_DEF = 2;

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control/status bundle between the motor-control loop and pwm_multi.
//   en           run enable (low holds counter, forces outputs low)
//   duty         packed duty values, channel i at [i*WIDTH +: WIDTH]
//   duty_wr      one-cycle strobe capturing duty into the shadow registers
//   mode         0 edge-aligned, 1 center-aligned (only with PWM_CENTER_ALIGN_EN)
//   PWM_sig      registered PWM outputs
//   period_tick  high during the last cycle of each period
//   upd_pending  shadow written but not yet transferred to active
// Modports: master = duty writer, slave = pwm_multi.
interface pwm_multi_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
);
  logic                      en;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      duty_wr;
`ifdef PWM_CENTER_ALIGN_EN
  logic                      mode;
`endif
  logic [CHANNELS-1:0]       PWM_sig;
  logic                      period_tick;
  logic                      upd_pending;

  modport master (
    output en, duty, duty_wr,
`ifdef PWM_CENTER_ALIGN_EN
    output mode,
`endif
    input  PWM_sig, period_tick, upd_pending
  );

  modport slave (
    input  en, duty, duty_wr,
`ifdef PWM_CENTER_ALIGN_EN
    input  mode,
`endif
    output PWM_sig, period_tick, upd_pending
  );
endinterface

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel with double-buffered duty.
//   clk, rst   clock and synchronous active-high reset
//   en         run enable; low forces the output low and loads active from shadow
//   terminal   last cycle of the current period (from the shared counter)
//   cnt        shared counter value
//   duty       this channel's duty slice
//   duty_wr    capture strobe for duty
//   pwm        registered output, high while cnt < active
module pwm_chan #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             terminal,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_wr,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (duty_wr) shadow <= duty;
      if (!en) begin
        active <= shadow;
        pwm    <= 1'b0;
      end else begin
        // A write landing in the terminal cycle goes straight to active so
        // it governs the very next period instead of waiting a full one.
        if (terminal) active <= duty_wr ? duty : shadow;
        pwm <= (cnt < active);
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS PWM outputs driven from one shared counter.
// Optional feature macro: PWM_CENTER_ALIGN_EN adds the mode input and
// center-aligned (up/down) counting; without it only edge-aligned runs.
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   pwm_multi_if.slave (en, duty, duty_wr, [mode], PWM_sig,
//         period_tick, upd_pending)
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEF,
  parameter int CHANNELS = PWM_CHANNELS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0]    cnt;
  logic                terminal;
  logic                upd_pending;
  logic [CHANNELS-1:0] pwm_q;

`ifdef PWM_CENTER_ALIGN_EN
  logic      dir_down;
  pwm_mode_e mode_act;

  assign terminal = (mode_act == PWM_CENTER) ? (dir_down && cnt == CNT_ONE)
                                             : (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dir_down    <= 1'b0;
      mode_act    <= PWM_EDGE;
      upd_pending <= 1'b0;
    end else if (!bus.en) begin
      cnt         <= '0;
      dir_down    <= 1'b0;
      mode_act    <= pwm_mode_e'(bus.mode);
      upd_pending <= 1'b0;
    end else if (terminal) begin
      // Both modes restart at cnt=0 counting up, so a mode switch here is clean.
      cnt         <= '0;
      dir_down    <= 1'b0;
      mode_act    <= pwm_mode_e'(bus.mode);
      upd_pending <= 1'b0;
    end else begin
      if (bus.duty_wr) upd_pending <= 1'b1;
      if (mode_act == PWM_CENTER && !dir_down && cnt == CNT_MAX) begin
        dir_down <= 1'b1;
        cnt      <= cnt - 1'b1;
      end else if (dir_down) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign terminal = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      upd_pending <= 1'b0;
    end else if (!bus.en) begin
      cnt         <= '0;
      upd_pending <= 1'b0;
    end else if (terminal) begin
      cnt         <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (bus.duty_wr) upd_pending <= 1'b1;
      cnt <= cnt + 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .terminal (terminal),
      .cnt      (cnt),
      .duty     (bus.duty[i*WIDTH +: WIDTH]),
      .duty_wr  (bus.duty_wr),
      .pwm      (pwm_q[i])
    );
  end

  assign bus.PWM_sig     = pwm_q;
  assign bus.period_tick = terminal && bus.en;
  assign bus.upd_pending = upd_pending;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator that replaces the single-channel 10-bit generator in the motor-drive path. Drives CHANNELS outputs from one shared counter, with parametrised resolution. Duty updates are double-buffered, so a new duty value only takes effect at a period boundary and never produces a glitched pulse. The block sits between the motor-control loop, which writes duties, and the motor driver pins.

## Interface
- WIDTH, 10, counter and duty resolution in bits; M = 2^WIDTH-1
- CHANNELS, 2, number of independent PWM outputs
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low holds the counter and forces outputs low
- duty  in  CHANNELS*WIDTH  duty values; channel i at bits [i*WIDTH +: WIDTH]
- duty_wr  in  1  one-cycle strobe that captures all of duty into the shadow registers
- mode  in  1  0 = edge-aligned, 1 = center-aligned (present only with PWM_CENTER_ALIGN_EN)
- PWM_sig  out  CHANNELS  registered PWM outputs
- period_tick  out  1  high during the last cycle of each period
- upd_pending  out  1  shadow written but not yet transferred to active

## Operation
- Reset values:
  - cnt=0, dir=up
  - shadow=0, active=0
  - PWM_sig=0, period_tick=0, upd_pending=0
  - mode_act=0
- Edge-aligned counting: cnt runs 0..M, then wraps to 0. Period is 2^WIDTH cycles.
- Terminal cycle (edge-aligned): the cycle where cnt==M.
- Comparison: PWM_sig[i] is registered from (cnt < active[i]).
  - High cycles per period equal active[i].
  - duty=0 gives a constant low output.
  - duty=M gives low for 1 cycle per period.
- duty_wr: shadow <= duty and upd_pending <= 1.
- Transfer: in the terminal cycle, active <= shadow and upd_pending <= 0.
  - The new duty governs the period starting at the next cnt=0.
- duty_wr in the terminal cycle: the written value bypasses the shadow straight into active, and upd_pending stays 0.
- Repeated duty_wr within one period: the last write wins.
- period_tick is combinational on terminal && en.
- en low:
  - cnt held at 0, dir=up
  - PWM_sig forced to 0, period_tick=0
  - active <= shadow every cycle, upd_pending=0
- en rising edge: counting starts at cnt=0 on the next cycle.
- rst asserted mid-period: all state returns to reset values on that edge. A pending update is discarded.

## Timing
- PWM_sig lags the cnt value it is compared against by 1 cycle.
- duty_wr to output effect:
  - Best case 1 cycle (write in the terminal cycle).
  - Worst case 2^WIDTH cycles (edge-aligned) or 2M cycles (center-aligned).
- Active duty never changes except at a terminal cycle or while en is low.
- No combinational path from duty or duty_wr to PWM_sig.

## Configuration
- PWM_CENTER_ALIGN_EN defined:
  - Adds the mode input and the dir register.
  - Center-aligned sequence: 0,1,…,M,M-1,…,1, repeating. Period is 2M cycles.
  - Terminal cycle (center-aligned): cnt==1 with dir=down.
  - High cycles per period: 2*active-1 for active ≥ 1, and 0 for active=0.
  - mode is sampled into mode_act only at the terminal cycle, or while en is low. A mode change mid-period takes effect at the next boundary.
- PWM_CENTER_ALIGN_EN undefined:
  - No mode port, no dir register.
  - Edge-aligned operation only.

## Structure
- Shared package pwm_pkg holds:
  - enum pwm_mode_e {PWM_EDGE, PWM_CENTER}
  - Default localparams PWM_WIDTH_DEF=10 and PWM_CHANNELS_DEF=2
- Sub-module pwm_chan, instantiated CHANNELS times. Each instance holds:
  - its shadow and active registers
  - the compare and the output flop
  - inputs: shared cnt, terminal, en, and its duty slice
- The top level holds the counter, dir, mode_act and upd_pending.

## Test plan
All scenarios use WIDTH=4 (M=15), CHANNELS=2.
- Reset then en=1, duty={4,0}, duty_wr: ch1 low, ch0 high exactly 4 of every 16 cycles from the second period on; period_tick every 16 cycles.
- duty_wr of 8 when cnt=5, previous duty 3: rest of current period still 3 high, next period 8 high; upd_pending high from cnt=6 to the terminal cycle.
- duty_wr of 15 exactly at cnt=15: the next period shows 15 high and 1 low; upd_pending never asserts.
- en dropped at cnt=9: PWM_sig=0 the next cycle and cnt=0. Re-enable: a full clean period, with the shadow value applied immediately.
- rst at cnt=7 with an update pending: all outputs 0, upd_pending=0; after release, active=0 and PWM_sig stays low.
- With PWM_CENTER_ALIGN_EN, mode=1, duty=4: period 30 cycles, 7 high cycles centred on cnt=0; mode toggled mid-period takes effect only after the next period_tick.
